// File: rtl/keypad_pkg.sv
// Shared constants and state encoding for the keypad letter / radio TX path.
// WORD_TX_PARITY_EN adds the PARITY state used for 8E1 framing.
package keypad_pkg;

  localparam logic [7:0] ASCII_A           = 8'h41;
  localparam logic [7:0] ASCII_Z           = 8'h5A;
  localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0A;
  localparam logic [7:0] EOT_CHAR_DEFAULT  = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef WORD_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    NEXT
  } tx_state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity
// (WORD_TX_PARITY_EN), one stop bit. ack is high in the last stop-bit cycle.
//   state  | meaning
//   IDLE   | line high, waiting for start
//   START  | start bit (low)
//   DATA   | data bits, bit 0 first
//   PARITY | even parity bit (WORD_TX_PARITY_EN only)
//   STOP   | stop bit (high)
module uart_tx_byte
  import keypad_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ack
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_last;

  assign baud_last = (cnt == BAUD_LAST);
  // Combinational so the word sequencer can queue the next byte with only
  // one idle cycle between frames.
  assign ack = (state == STOP) && baud_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (start) begin
            shreg <= byte_in;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef WORD_TX_PARITY_EN
              tx    <= ^shreg;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef WORD_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/word_tx_fsm.sv
// Buffers keypad letters into a word and sends it (plus terminator, or an
// end-of-game byte) over the radio TX line. WORD_TX_PARITY_EN selects 8E1.
//   state | meaning
//   IDLE  | collecting letters, waiting for submit / game end
//   START | a byte is in flight in the serializer
//   NEXT  | one idle cycle between frames; finish or continue
module word_tx_fsm
  import keypad_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 100,
  parameter int         MAX_LEN      = 8,
  parameter logic [7:0] TERM_CHAR    = TERM_CHAR_DEFAULT,
  parameter logic [7:0] EOT_CHAR     = EOT_CHAR_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ready,
  input  logic [7:0]                   data,
  input  logic                         toggle_state,
  input  logic                         game_end,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] count,
  output logic                         overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  tx_state_t     state;
  logic          toggle_q, game_q, tog_rise, game_rise;
  logic [7:0]    word_buf [MAX_LEN];
  logic [CW-1:0] len, idx, idx_n;
  logic [7:0]    byte_q;
  logic          start_q, tx_ack;
  logic          is_eot, is_term, eot_pend, finish_q;

  assign tog_rise  = toggle_state & ~toggle_q;
  assign game_rise = game_end & ~game_q;
  assign idx_n     = idx + 1'b1;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (start_q),
    .byte_in (byte_q),
    .tx      (tx),
    .ack     (tx_ack)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      toggle_q <= 1'b0;
      game_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) word_buf[i] <= '0;
      len      <= '0;
      idx      <= '0;
      byte_q   <= '0;
      start_q  <= 1'b0;
      is_eot   <= 1'b0;
      is_term  <= 1'b0;
      eot_pend <= 1'b0;
      finish_q <= 1'b0;
      busy     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      toggle_q <= toggle_state;
      game_q   <= game_end;
      start_q  <= 1'b0;

      if (ready) begin
        if (busy) begin
          overflow <= 1'b1;
        end else if (is_letter(data)) begin
          if (count < MAX_CNT) begin
            word_buf[count[AW-1:0]] <= data;
            count <= count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end

      if (game_rise && state != IDLE) eot_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (game_rise) begin
            count   <= '0;
            byte_q  <= EOT_CHAR;
            is_eot  <= 1'b1;
            is_term <= 1'b0;
            start_q <= 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end else if (tog_rise && count != '0) begin
            len      <= count;
            idx      <= '0;
            byte_q   <= word_buf[0];
            overflow <= 1'b0;
            is_eot   <= 1'b0;
            is_term  <= 1'b0;
            start_q  <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          // The next byte is chosen as the stop bit ends, so its start bit
          // follows the single NEXT cycle.
          if (tx_ack) begin
            state    <= NEXT;
            finish_q <= 1'b0;
            if (is_eot) begin
              finish_q <= 1'b1;
              eot_pend <= 1'b0;
            end else if (is_term) begin
              if (eot_pend) begin
                byte_q   <= EOT_CHAR;
                is_eot   <= 1'b1;
                is_term  <= 1'b0;
                eot_pend <= 1'b0;
                count    <= '0;
                start_q  <= 1'b1;
              end else begin
                finish_q <= 1'b1;
              end
            end else begin
              idx     <= idx_n;
              start_q <= 1'b1;
              if (idx_n == len) begin
                byte_q  <= TERM_CHAR;
                is_term <= 1'b1;
              end else begin
                byte_q <= word_buf[idx_n[AW-1:0]];
              end
            end
          end
        end
        NEXT: begin
          if (finish_q) begin
            count   <= '0;
            busy    <= 1'b0;
            is_eot  <= 1'b0;
            is_term <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_tx_fsm.sv
// Directed bench for word_tx_fsm with CLKS_PER_BIT=4, MAX_LEN=8 (8N1 build).
module tb_word_tx_fsm;

  localparam int CPB = 4;
  localparam int ML  = 8;
  localparam int CW  = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst, ready, toggle_state, game_end;
  logic [7:0]    data;
  logic          tx, busy, overflow;
  logic [CW-1:0] count;

  int   ncmp = 0, nerr = 0, cyc = 0, last_fall = 0;
  logic busy_low;

  word_tx_fsm #(.CLKS_PER_BIT(CPB), .MAX_LEN(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .data         (data),
    .toggle_state (toggle_state),
    .game_end     (game_end),
    .tx           (tx),
    .busy         (busy),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic letter(input logic [7:0] d);
    data  = d;
    ready = 1'b1;
    step();
    ready = 1'b0;
    data  = 8'h00;
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({tag, " timeout"}, tx, 0);
  endtask

  // Samples each bit in the middle of its 4-cycle cell; returns at stop-bit mid.
  task automatic rx_byte(input string tag, input logic [7:0] exp, input int gap);
    logic [9:0] fr;
    wait_fall(tag);
    if (gap > 0) chk({tag, " gap"}, cyc - last_fall, gap);
    last_fall = cyc;
    step(2);
    fr[0] = tx;
    if (busy !== 1'b1) busy_low = 1'b1;
    for (int i = 1; i < 10; i++) begin
      step(4);
      fr[i] = tx;
      if (busy !== 1'b1) busy_low = 1'b1;
    end
    chk(tag, fr, {1'b1, exp, 1'b0});
  endtask

  task automatic quiet_check(input string tag);
    logic quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    chk(tag, quiet, 1);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; data = 8'h00; toggle_state = 1'b0; game_end = 1'b0;
    busy_low = 1'b0;
    step(2);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset count", count, 0);
    chk("reset overflow", overflow, 0);
    rst = 1'b0;
    step(2);

    // CAT word; toggle stays high so only its first cycle may act
    letter(8'h43); letter(8'h41); letter(8'h54);
    chk("cat count", count, 3);
    toggle_state = 1'b1;
    step();
    chk("busy after submit", busy, 1);
    chk("tx before start bit", tx, 1);
    step();
    chk("submit latency", tx, 0);
    rx_byte("byte C", 8'h43, 0);
    rx_byte("byte A", 8'h41, 41);
    rx_byte("byte T", 8'h54, 41);
    rx_byte("cat term", 8'h0A, 41);
    step(2);
    chk("busy in NEXT", busy, 1);
    step();
    chk("busy end cat", busy, 0);
    chk("count end cat", count, 0);
    quiet_check("single word");
    toggle_state = 1'b0;
    step(2);

    // empty buffer submit
    toggle_state = 1'b1;
    quiet_check("empty submit");
    toggle_state = 1'b0;
    step();

    // non-letters, including the codes just outside A..Z
    letter(8'h00); letter(8'h31); letter(8'h40); letter(8'h5B);
    chk("invalid count", count, 0);
    chk("invalid overflow", overflow, 0);

    // nine letters into an eight-deep buffer
    for (int i = 0; i < 9; i++) letter(8'h41 + 8'(i));
    chk("full count", count, 8);
    chk("full overflow", overflow, 1);
    toggle_state = 1'b1;
    step();
    chk("overflow cleared", overflow, 0);
    for (int i = 0; i < 8; i++) rx_byte("long byte", 8'h41 + 8'(i), (i == 0) ? 0 : 41);
    rx_byte("long term", 8'h0A, 41);
    step(3);
    chk("busy end long", busy, 0);
    chk("count end long", count, 0);
    toggle_state = 1'b0;
    step(2);

    // game end during a word, plus a letter while busy
    letter(8'h5A); letter(8'h41); letter(8'h50);
    chk("zap count", count, 3);
    toggle_state = 1'b1;
    step();
    busy_low = 1'b0;
    rx_byte("byte Z", 8'h5A, 0);
    game_end = 1'b1;
    letter(8'h51);
    chk("busy drop overflow", overflow, 1);
    chk("busy drop count", count, 3);
    rx_byte("byte A2", 8'h41, 41);
    rx_byte("byte P", 8'h50, 41);
    rx_byte("zap term", 8'h0A, 41);
    rx_byte("eot after word", 8'h04, 41);
    chk("busy held", busy_low, 0);
    step(3);
    chk("busy end eot", busy, 0);
    chk("count end eot", count, 0);
    toggle_state = 1'b0;
    game_end = 1'b0;
    step(2);

    // asynchronous reset during DATA of the second byte ('Y' bit 1 is 0)
    letter(8'h58); letter(8'h59);
    toggle_state = 1'b1;
    step();
    rx_byte("byte X", 8'h58, 0);
    wait_fall("second byte");
    step(9);
    chk("pre-reset tx", tx, 0);
    rst = 1'b1;
    #2;
    chk("async rst tx", tx, 1);
    chk("async rst busy", busy, 0);
    chk("async rst count", count, 0);
    toggle_state = 1'b0;
    step();
    rst = 1'b0;
    step(2);
    toggle_state = 1'b1;
    quiet_check("submit after reset");
    toggle_state = 1'b0;
    step();

    // game end from idle
    game_end = 1'b1;
    step();
    chk("eot busy", busy, 1);
    rx_byte("eot idle", 8'h04, 0);
    step(3);
    chk("eot idle busy end", busy, 0);
    chk("eot idle count", count, 0);
    game_end = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/word_tx_fsm.md
Name: word_tx_fsm

Overview:
- Consumer end of the keypad letter interface (ready/data/toggle_state/game_end).
- Buffers submitted letters into a word.
- On word submission, transmits the word serially (UART 8N1, LSB first) to the wireless module, followed by a terminator byte.
- On game end, transmits a single end-of-game byte.
- Sits between the keypad FSM and the radio TX pin.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit (must be >=2).
- MAX_LEN, 8, word buffer depth in letters.
- TERM_CHAR, 8'h0A, byte sent after the last letter of a word.
- EOT_CHAR, 8'h04, byte sent on game end.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ready  input  1  one-cycle pulse: data holds a submitted letter.
- data  input  8  ASCII letter from the keypad.
- toggle_state  input  1  word-submit level (may stay high for many cycles).
- game_end  input  1  game-end level (may stay high for many cycles).
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is being transmitted.
- count  output  $clog2(MAX_LEN+1)  letters currently buffered.
- overflow  output  1  sticky: a letter was dropped (buffer full, or dropped while busy).

Behaviour:
- Reset values: tx=1, busy=0, count=0, overflow=0, all state cleared. Reset mid-frame aborts immediately and tx returns to 1 with no partial stop bit.
- Edge detection: toggle_state and game_end are rising-edge detected with one register each; only the first cycle of each level acts.
- Letter capture: on ready=1 with busy=0 and data in 8'h41..8'h5A:
  - count<MAX_LEN: write data to buf[count]; count increments next cycle.
  - count==MAX_LEN: letter dropped, overflow set.
- Ignored letters: data outside A-Z (including 0) is ignored silently. ready while busy=1 is dropped and sets overflow.
- overflow clears only on reset or on the start of a word transmission.
- FSM states: IDLE, START, DATA, STOP, NEXT.
- IDLE:
  - toggle rising edge with count>0: latch len=count, idx=0, shift=buf[0]; go START; busy=1 from the next cycle.
  - toggle rising edge with count==0: ignored.
  - game_end rising edge: clear count, shift=EOT_CHAR, mark frame as EOT; go START.
  - game_end has priority over toggle in the same cycle.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[bit], bit 0 first, each bit held CLKS_PER_BIT cycles; 3-bit bit counter wraps 7->0 into STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to NEXT.
- NEXT (1 cycle):
  - EOT frame, or terminator just sent: count=0, busy=0, go IDLE.
  - Else idx++. If idx==len, load TERM_CHAR; else load buf[idx]. Go START.
- Line timing:
  - Back-to-back bytes have exactly one extra idle-high cycle (NEXT) between the stop bit and the next start bit.
  - Latency from toggle rising edge to tx falling edge is 2 cycles.
- game_end edge while busy: latched into a pending flag. After the current frame's terminator, the EOT frame is sent without returning busy low; count is cleared.
- Baud counter: counts 0..CLKS_PER_BIT-1; $clog2(CLKS_PER_BIT) bits wide; wraps to 0 at each bit boundary.
- Frame on wire: MAX_LEN letters maximum plus terminator; letter order equals capture order.

Optional Feature:
- WORD_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP, held CLKS_PER_BIT cycles (8E1 framing) via an extra PARITY state.
- Undefined: 8N1 framing; the PARITY state does not exist.

Decomposition:
- Shared package keypad_pkg:
  - ASCII bounds 8'h41/8'h5A.
  - TERM_CHAR/EOT_CHAR defaults.
  - tx_state_t enum.
- Sub-module uart_tx_byte: byte serializer with start/ack handshake, containing the baud counter and START/DATA/(PARITY)/STOP.
- word_tx_fsm keeps the buffer, edge detectors, and the IDLE/NEXT sequencing.

Test Plan:
- CLKS_PER_BIT=4. Pulse ready with 'C','A','T', then toggle high 5 cycles -> tx carries 8'h43, 8'h41, 8'h54, 8'h0A, LSB first, 40 cycles per byte plus 1 idle cycle between bytes; busy then falls, count=0, and only one word is sent.
- Toggle edge with count=0 -> tx stays 1, busy stays 0.
- Nine valid letters with MAX_LEN=8 -> count=8, overflow=1; the ninth letter is absent on the wire; overflow clears when the word transmission starts.
- ready with data=8'h00 and data=8'h31 -> count unchanged, overflow=0.
- game_end asserted mid-word -> word and terminator complete, then 8'h04 is sent; busy stays high throughout; count=0 at the end.
- rst asserted during DATA of the second byte -> tx=1, busy=0, count=0 in the same cycle (asynchronous); the next toggle with an empty buffer is ignored.
